// File: rtl/rtc_core_scan_if.sv
// Load-time handshake between a time-setting requester and the RTC core.
// The requester drives a candidate HH:MM:SS with set_valid and holds it until
// set_ready is seen; the core answers a rejected load with a one-cycle set_err.
interface rtc_core_scan_if;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_h;
    logic [5:0] set_m;
    logic [5:0] set_s;
    logic       set_err;

    modport master (
        output set_valid, set_h, set_m, set_s,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_h, set_m, set_s,
        output set_ready, set_err
    );
endinterface

// File: rtl/rtc_core_scan.sv
// Time-of-day core: single-clock HH:MM:SS counter with a second prescaler,
// load handshake, registered unit tick pulses and a round-robin display
// scanner presenting hours/minutes/seconds on one zero-extended bus.
module rtc_core_scan #(
    parameter int DIV      = 100,
    parameter int SCAN_DIV = 1,
    parameter int OUT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode12,
    rtc_core_scan_if.slave   set_if,
    output logic [4:0]       hours,
    output logic [5:0]       minutes,
    output logic [5:0]       seconds,
    output logic             sec_tick,
    output logic             min_tick,
    output logic             hour_tick,
    output logic             day_tick,
    output logic [OUT_W-1:0] disp,
    output logic [1:0]       disp_sel,
    output logic             pm
);

    localparam int P_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        SEL_HOURS   = 2'd0,
        SEL_MINUTES = 2'd1,
        SEL_SECONDS = 2'd2
    } sel_e;

    logic [P_W-1:0]   r_p;
    logic [4:0]       r_hours;
    logic [5:0]       r_minutes;
    logic [5:0]       r_seconds;
    logic             r_sec_tick;
    logic             r_min_tick;
    logic             r_hour_tick;
    logic             r_day_tick;
    logic             r_ready;
    logic             r_err;
    logic [S_W-1:0]   r_slot;
    sel_e             r_sel;
    sel_e             w_sel_next;
    logic [OUT_W-1:0] r_disp;

    logic             w_accept;
    logic             w_set_ok;
    logic             w_load;
    logic             w_p_wrap;
    logic             w_step;
    logic             w_s_wrap;
    logic             w_m_wrap;
    logic             w_h_wrap;
    logic             w_slot_wrap;
    logic [4:0]       w_hours12;
    logic [5:0]       w_field;

    // A valid load takes priority over a prescaler wrap on the same edge, so
    // the second step is suppressed whenever a good value is being written.
    assign w_accept = set_if.set_valid && r_ready;
    assign w_set_ok = (set_if.set_h <= 5'd23) && (set_if.set_m <= 6'd59) &&
                      (set_if.set_s <= 6'd59);
    assign w_load   = w_accept && w_set_ok;
    assign w_p_wrap = en && (r_p == P_W'(DIV - 1));
    assign w_step   = w_p_wrap && !w_load;
    assign w_s_wrap = w_step   && (r_seconds == 6'd59);
    assign w_m_wrap = w_s_wrap && (r_minutes == 6'd59);
    assign w_h_wrap = w_m_wrap && (r_hours   == 5'd23);

    // Prescaler: counts clk cycles per second while enabled, restarts on load.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (w_load) begin
            r_p <= '0;
        end else if (en) begin
            r_p <= w_p_wrap ? '0 : r_p + P_W'(1);
        end
    end

    // Time registers: load on accepted good set, otherwise cascade on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hours   <= '0;
            r_minutes <= '0;
            r_seconds <= '0;
        end else if (w_load) begin
            r_hours   <= set_if.set_h;
            r_minutes <= set_if.set_m;
            r_seconds <= set_if.set_s;
        end else if (w_step) begin
            r_seconds <= w_s_wrap ? 6'd0 : r_seconds + 6'd1;
            if (w_s_wrap) begin
                r_minutes <= w_m_wrap ? 6'd0 : r_minutes + 6'd1;
            end
            if (w_m_wrap) begin
                r_hours <= w_h_wrap ? 5'd0 : r_hours + 5'd1;
            end
        end
    end

    // Registered tick pulses, coincident with the updated time value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_day_tick  <= 1'b0;
        end else begin
            r_sec_tick  <= w_step;
            r_min_tick  <= w_s_wrap;
            r_hour_tick <= w_m_wrap;
            r_day_tick  <= w_h_wrap;
        end
    end

    // Load handshake: ready rises the first edge out of reset and drops for
    // exactly one cycle after each accept; bad values flag set_err instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= !w_accept;
            r_err   <= w_accept && !w_set_ok;
        end
    end

    // Scanner slot timer: holds each display field for SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_wrap ? '0 : r_slot + S_W'(1);
        end
    end

    assign w_slot_wrap = (r_slot == S_W'(SCAN_DIV - 1));

    // Field selector state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= SEL_HOURS;
        end else begin
            r_sel <= w_sel_next;
        end
    end

    // Field selector next state: hours -> minutes -> seconds -> hours.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel_next = r_sel;
        if (w_slot_wrap) begin
            case (r_sel)
                SEL_HOURS:   w_sel_next = SEL_MINUTES;
                SEL_MINUTES: w_sel_next = SEL_SECONDS;
                default:     w_sel_next = SEL_HOURS;
            endcase
        end
    end

    // 12h presentation of the hours counter: 0 shows as 12, 13..23 as 1..11.
    always_comb begin
        w_hours12 = r_hours;
        if (r_hours == 5'd0) begin
            w_hours12 = 5'd12;
        end else if (r_hours > 5'd12) begin
            w_hours12 = r_hours - 5'd12;
        end
    end

    // Field mux for the display; only the hours slot reacts to mode12.
    always_comb begin
        w_field = 6'd0;
        case (r_sel)
            SEL_HOURS:   w_field = {1'b0, mode12 ? w_hours12 : r_hours};
            SEL_MINUTES: w_field = r_minutes;
            default:     w_field = r_seconds;
        endcase
    end

    // Display register: one cycle behind the selected field and selector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
        end else begin
            r_disp <= OUT_W'(w_field);
        end
    end

    assign set_if.set_ready = r_ready;
    assign set_if.set_err   = r_err;
    assign hours            = r_hours;
    assign minutes          = r_minutes;
    assign seconds          = r_seconds;
    assign sec_tick         = r_sec_tick;
    assign min_tick         = r_min_tick;
    assign hour_tick        = r_hour_tick;
    assign day_tick         = r_day_tick;
    assign disp             = r_disp;
    assign disp_sel         = r_sel;
    assign pm               = (r_hours >= 5'd12);

endmodule
